calc3_req_sched: RTL and testbench

- Request scheduler in front of the shared calc3 execution pipe.
- Captures single-cycle command pulses from the four requester ports into per-port queues.
- Blocks commands with register hazards using a 16-entry busy scoreboard.
- Issues one command per cycle to the pipe, chosen round-robin among eligible ports through a valid/ready handshake.

---
 rtl/calc3_req_sched.sv | 191 +++++++++++++++++++
 tb/tb_calc3_req_sched.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc3_req_sched.sv
// Request scheduler for the calc3 pipe: four per-port command queues, a register
// busy scoreboard and a round-robin issue stage with a valid/ready handshake.
module calc3_req_sched #(
    parameter int DEPTH = 2,
    parameter int NREG  = 16
) (
    input  logic            c_clk,
    input  logic            reset,
    input  logic [3:0]      req1_cmd,
    input  logic [1:0]      req1_tag,
    input  logic [3:0]      req1_d1,
    input  logic [3:0]      req1_d2,
    input  logic [3:0]      req1_r1,
    input  logic [31:0]     req1_data,
    input  logic [3:0]      req2_cmd,
    input  logic [1:0]      req2_tag,
    input  logic [3:0]      req2_d1,
    input  logic [3:0]      req2_d2,
    input  logic [3:0]      req2_r1,
    input  logic [31:0]     req2_data,
    input  logic [3:0]      req3_cmd,
    input  logic [1:0]      req3_tag,
    input  logic [3:0]      req3_d1,
    input  logic [3:0]      req3_d2,
    input  logic [3:0]      req3_r1,
    input  logic [31:0]     req3_data,
    input  logic [3:0]      req4_cmd,
    input  logic [1:0]      req4_tag,
    input  logic [3:0]      req4_d1,
    input  logic [3:0]      req4_d2,
    input  logic [3:0]      req4_r1,
    input  logic [31:0]     req4_data,
    output logic [3:0]      port_full,
    output logic            drop_err,
    output logic [1:0]      drop_port,
    output logic            iss_valid,
    input  logic            iss_ready,
    output logic [1:0]      iss_port,
    output logic [3:0]      iss_cmd,
    output logic [1:0]      iss_tag,
    output logic [3:0]      iss_d1,
    output logic [3:0]      iss_d2,
    output logic [3:0]      iss_r1,
    output logic [31:0]     iss_data,
    input  logic            cmp_valid,
    input  logic [3:0]      cmp_r1,
    output logic [NREG-1:0] busy_regs
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  tag;
        logic [3:0]  d1;
        logic [3:0]  d2;
        logic [3:0]  r1;
        logic [31:0] data;
    } entry_t;

    function automatic logic f_reads_d1(input logic [3:0] c);
        return c inside {4'd1, 4'd2, 4'd5, 4'd6, 4'd13, 4'd10, 4'd12};
    endfunction

    function automatic logic f_reads_d2(input logic [3:0] c);
        return c inside {4'd1, 4'd2, 4'd5, 4'd6, 4'd13};
    endfunction

    function automatic logic f_writes_r1(input logic [3:0] c);
        return c inside {4'd1, 4'd2, 4'd5, 4'd6, 4'd9};
    endfunction

    entry_t          w_in      [4];
    entry_t          w_head    [4];
    entry_t          r_mem     [4][DEPTH];
    logic [AW-1:0]   r_wp      [4];
    logic [AW-1:0]   r_rp      [4];
    logic [AW:0]     r_cnt     [4];
    logic [AW:0]     w_cnt_nxt [4];
    logic [3:0]      w_push, w_drop, w_pop, w_elig;
    logic [1:0]      r_ptr, w_sel, w_drop_port;
    logic            w_any, w_grant;
    logic [NREG-1:0] r_busy, w_busy_nxt;
    logic [3:0]      r_full;
    logic            r_drop_err;
    logic [1:0]      r_drop_port;
    entry_t          w_iss;

    assign w_in[0] = {req1_cmd, req1_tag, req1_d1, req1_d2, req1_r1, req1_data};
    assign w_in[1] = {req2_cmd, req2_tag, req2_d1, req2_d2, req2_r1, req2_data};
    assign w_in[2] = {req3_cmd, req3_tag, req3_d1, req3_d2, req3_r1, req3_data};
    assign w_in[3] = {req4_cmd, req4_tag, req4_d1, req4_d2, req4_r1, req4_data};

    // A head is eligible only when none of its source or destination registers is pending.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            w_head[p] = r_mem[p][r_rp[p]];
            w_elig[p] = (r_cnt[p] != '0)
                     && !(f_reads_d1(w_head[p].cmd)  && r_busy[w_head[p].d1])
                     && !(f_reads_d2(w_head[p].cmd)  && r_busy[w_head[p].d2])
                     && !(f_writes_r1(w_head[p].cmd) && r_busy[w_head[p].r1]);
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int i = 1; i <= 4; i++) begin
            if (!w_any && w_elig[r_ptr + 2'(i)]) begin
                w_any = 1'b1;
                w_sel = r_ptr + 2'(i);
            end
        end
    end

    assign w_grant = w_any && iss_ready;
    assign w_iss   = w_any ? w_head[w_sel] : '0;

    always_comb begin
        w_drop_port = '0;
        for (int p = 3; p >= 0; p--) begin
            w_push[p]    = (w_in[p].cmd != 4'd0) && (r_cnt[p] != FULL_CNT);
            w_drop[p]    = (w_in[p].cmd != 4'd0) && (r_cnt[p] == FULL_CNT);
            w_pop[p]     = w_grant && (w_sel == 2'(p));
            w_cnt_nxt[p] = r_cnt[p] + (AW+1)'(w_push[p]) - (AW+1)'(w_pop[p]);
            if (w_drop[p])
                w_drop_port = 2'(p);
        end
    end

    // Set is applied after clear so a same-edge retire cannot free a newly granted writer.
    always_comb begin
        w_busy_nxt = r_busy;
        if (cmp_valid)
            w_busy_nxt[cmp_r1] = 1'b0;
        if (w_grant && f_writes_r1(w_iss.cmd))
            w_busy_nxt[w_iss.r1] = 1'b1;
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 4; p++) begin
                r_wp[p]  <= '0;
                r_rp[p]  <= '0;
                r_cnt[p] <= '0;
            end
            r_ptr       <= 2'd3;
            r_busy      <= '0;
            r_full      <= '0;
            r_drop_err  <= 1'b0;
            r_drop_port <= '0;
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (w_push[p])
                    r_wp[p] <= r_wp[p] + AW'(1);
                if (w_pop[p])
                    r_rp[p] <= r_rp[p] + AW'(1);
                r_cnt[p]  <= w_cnt_nxt[p];
                r_full[p] <= (w_cnt_nxt[p] == FULL_CNT);
            end
            if (w_grant)
                r_ptr <= w_sel;
            r_busy      <= w_busy_nxt;
            r_drop_err  <= |w_drop;
            r_drop_port <= w_drop_port;
        end
    end

    // NOTE: queue storage has no reset; the counts alone decide which slots are live.
    always_ff @(posedge c_clk) begin
        for (int p = 0; p < 4; p++) begin
            if (w_push[p])
                r_mem[p][r_wp[p]] <= w_in[p];
        end
    end

    assign port_full = r_full;
    assign drop_err  = r_drop_err;
    assign drop_port = r_drop_port;
    assign busy_regs = r_busy;
    assign iss_valid = w_any;
    assign iss_port  = w_any ? w_sel : 2'd0;
    assign iss_cmd   = w_iss.cmd;
    assign iss_tag   = w_iss.tag;
    assign iss_d1    = w_iss.d1;
    assign iss_d2    = w_iss.d2;
    assign iss_r1    = w_iss.r1;
    assign iss_data  = w_iss.data;

endmodule

// File: tb/tb_calc3_req_sched.sv
// Bench for calc3_req_sched: queue/scoreboard reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_calc3_req_sched;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  tag;
        logic [3:0]  d1;
        logic [3:0]  d2;
        logic [3:0]  r1;
        logic [31:0] data;
    } ent_t;

    logic        c_clk = 1'b0;
    logic        reset;
    logic [3:0]  t_cmd  [4];
    logic [1:0]  t_tag  [4];
    logic [3:0]  t_d1   [4];
    logic [3:0]  t_d2   [4];
    logic [3:0]  t_r1   [4];
    logic [31:0] t_data [4];
    logic        iss_ready, cmp_valid;
    logic [3:0]  cmp_r1;
    logic [3:0]  port_full;
    logic        drop_err;
    logic [1:0]  drop_port;
    logic        iss_valid;
    logic [1:0]  iss_port;
    logic [3:0]  iss_cmd;
    logic [1:0]  iss_tag;
    logic [3:0]  iss_d1, iss_d2, iss_r1;
    logic [31:0] iss_data;
    logic [15:0] busy_regs;

    calc3_req_sched #(.DEPTH(DEPTH), .NREG(16)) dut (
        .c_clk(c_clk), .reset(reset),
        .req1_cmd(t_cmd[0]), .req1_tag(t_tag[0]), .req1_d1(t_d1[0]), .req1_d2(t_d2[0]),
        .req1_r1(t_r1[0]), .req1_data(t_data[0]),
        .req2_cmd(t_cmd[1]), .req2_tag(t_tag[1]), .req2_d1(t_d1[1]), .req2_d2(t_d2[1]),
        .req2_r1(t_r1[1]), .req2_data(t_data[1]),
        .req3_cmd(t_cmd[2]), .req3_tag(t_tag[2]), .req3_d1(t_d1[2]), .req3_d2(t_d2[2]),
        .req3_r1(t_r1[2]), .req3_data(t_data[2]),
        .req4_cmd(t_cmd[3]), .req4_tag(t_tag[3]), .req4_d1(t_d1[3]), .req4_d2(t_d2[3]),
        .req4_r1(t_r1[3]), .req4_data(t_data[3]),
        .port_full(port_full), .drop_err(drop_err), .drop_port(drop_port),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_port(iss_port),
        .iss_cmd(iss_cmd), .iss_tag(iss_tag), .iss_d1(iss_d1), .iss_d2(iss_d2),
        .iss_r1(iss_r1), .iss_data(iss_data),
        .cmp_valid(cmp_valid), .cmp_r1(cmp_r1), .busy_regs(busy_regs)
    );

    always #5 c_clk = ~c_clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: one FIFO per port, a busy bit per register, last-granted port.
    ent_t      mq [4][$];
    bit [15:0] mbusy;
    int        mptr;
    bit        mdrop;
    int        mdrop_port;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_reads1(input logic [3:0] c);
        return c == 1 || c == 2 || c == 5 || c == 6 || c == 13 || c == 10 || c == 12;
    endfunction

    function automatic bit m_reads2(input logic [3:0] c);
        return c == 1 || c == 2 || c == 5 || c == 6 || c == 13;
    endfunction

    function automatic bit m_writes(input logic [3:0] c);
        return c == 1 || c == 2 || c == 5 || c == 6 || c == 9;
    endfunction

    function automatic bit m_elig(input int p);
        ent_t h;
        if (mq[p].size() == 0) return 1'b0;
        h = mq[p][0];
        if (m_reads1(h.cmd) && mbusy[h.d1]) return 1'b0;
        if (m_reads2(h.cmd) && mbusy[h.d2]) return 1'b0;
        if (m_writes(h.cmd) && mbusy[h.r1]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_pick();
        for (int k = 1; k <= 4; k++)
            if (m_elig((mptr + k) % 4)) return (mptr + k) % 4;
        return -1;
    endfunction

    task automatic m_clear();
        for (int p = 0; p < 4; p++) mq[p].delete();
        mbusy      = '0;
        mptr       = 3;
        mdrop      = 1'b0;
        mdrop_port = 0;
    endtask

    task automatic compare_all();
        int         sel;
        logic [3:0] ef;
        sel = m_pick();
        check("iss_valid", iss_valid, sel >= 0);
        if (sel >= 0) begin
            check("iss_port", iss_port, sel);
            check("iss_cmd",  iss_cmd,  mq[sel][0].cmd);
            check("iss_tag",  iss_tag,  mq[sel][0].tag);
            check("iss_d1",   iss_d1,   mq[sel][0].d1);
            check("iss_d2",   iss_d2,   mq[sel][0].d2);
            check("iss_r1",   iss_r1,   mq[sel][0].r1);
            check("iss_data", iss_data, mq[sel][0].data);
        end
        for (int p = 0; p < 4; p++) ef[p] = (mq[p].size() == DEPTH);
        check("port_full", port_full, ef);
        check("busy_regs", busy_regs, mbusy);
        check("drop_err",  drop_err,  mdrop);
        if (mdrop) check("drop_port", drop_port, mdrop_port);
    endtask

    task automatic model_step();
        int   sel;
        bit   grant;
        bit   full [4];
        ent_t h;
        sel   = m_pick();
        grant = (sel >= 0) && iss_ready;
        for (int p = 0; p < 4; p++) full[p] = (mq[p].size() == DEPTH);
        if (grant) begin
            h    = mq[sel].pop_front();
            mptr = sel;
        end
        mdrop = 1'b0;
        for (int p = 3; p >= 0; p--) begin
            if (t_cmd[p] != 4'd0) begin
                if (full[p]) begin
                    mdrop      = 1'b1;
                    mdrop_port = p;
                end else begin
                    mq[p].push_back(ent_t'({t_cmd[p], t_tag[p], t_d1[p], t_d2[p], t_r1[p], t_data[p]}));
                end
            end
        end
        if (cmp_valid) mbusy[cmp_r1] = 1'b0;
        if (grant && m_writes(h.cmd)) mbusy[h.r1] = 1'b1;
    endtask

    task automatic clear_req();
        for (int p = 0; p < 4; p++) begin
            t_cmd[p] = '0; t_tag[p] = '0; t_d1[p] = '0;
            t_d2[p]  = '0; t_r1[p]  = '0; t_data[p] = '0;
        end
    endtask

    task automatic set_req(input int p, input int cmd, input int tag, input int d1,
                           input int d2, input int r1, input int data);
        t_cmd[p]  = 4'(cmd);
        t_tag[p]  = 2'(tag);
        t_d1[p]   = 4'(d1);
        t_d2[p]   = 4'(d2);
        t_r1[p]   = 4'(r1);
        t_data[p] = 32'(data);
    endtask

    // Called just after a falling edge: check, advance the model, cross one rising edge.
    task automatic tick();
        compare_all();
        if (!reset) model_step();
        @(posedge c_clk);
        @(negedge c_clk);
        clear_req();
        cmp_valid = 1'b0;
    endtask

    task automatic do_reset_async();
        #2 reset = 1'b1;
        m_clear();
        #1;
        check("rst_iss_valid", iss_valid, 0);
        check("rst_port_full", port_full, 0);
        check("rst_busy",      busy_regs, 0);
        check("rst_drop_err",  drop_err,  0);
        check("rst_drop_port", drop_port, 0);
        check("rst_iss_cmd",   iss_cmd,   0);
        check("rst_iss_data",  iss_data,  0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        iss_ready = 1'b0;
        cmp_valid = 1'b0;
        cmp_r1    = '0;
        clear_req();
        m_clear();
        repeat (2) @(negedge c_clk);
        check("init_iss_valid", iss_valid, 0);
        check("init_busy",      busy_regs, 0);
        check("init_full",      port_full, 0);
        check("init_iss_port",  iss_port,  0);
        reset = 1'b0;

        // Store on port 1 issues the next cycle and marks r1 busy once granted.
        iss_ready = 1'b1;
        set_req(0, 9, 0, 0, 0, 1, 10);
        tick();
        check("t1_valid", iss_valid, 1);
        check("t1_port",  iss_port,  0);
        check("t1_cmd",   iss_cmd,   9);
        check("t1_data",  iss_data,  10);
        check("t1_r1",    iss_r1,    1);
        tick();
        check("t1_busy1",       busy_regs[1], 1);
        check("t1_model_busy1", mbusy[1],     1);
        cmp_valid = 1'b1; cmp_r1 = 4'd1;
        tick();
        check("t1_busy_clr", busy_regs, 0);

        // Simultaneous burst on all ports issues 0,1,2,3; next burst starts at port 1 again.
        do_reset_async();
        for (int p = 0; p < 4; p++) set_req(p, 1, p, 8 + p, 12 + p, 4 + p, 256 + p);
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_order%0d", k), iss_port, k);
            tick();
        end
        check("t2_idle", iss_valid, 0);
        check("t2_busy", busy_regs, 16'h00f0);
        for (int k = 0; k < 4; k++) begin
            cmp_valid = 1'b1; cmp_r1 = 4'(4 + k);
            tick();
        end
        for (int p = 0; p < 4; p++) set_req(p, 1, 0, 8 + p, 12 + p, 4 + p, p);
        tick();
        check("t2_again_port0", iss_port, 0);
        check("t2_model_pick",  m_pick(), 0);
        repeat (4) tick();
        for (int k = 0; k < 4; k++) begin
            cmp_valid = 1'b1; cmp_r1 = 4'(4 + k);
            tick();
        end

        // RAW hazard on port 2 stalls only port 2 until r5 retires.
        do_reset_async();
        set_req(1, 1, 1, 0, 0, 5, 0);
        tick();
        check("t3_first", iss_port, 1);
        tick();
        set_req(1, 2, 1, 5, 0, 6, 0);
        tick();
        check("t3_blocked", iss_valid, 0);
        set_req(2, 1, 2, 1, 2, 3, 0);
        tick();
        check("t3_p3_valid", iss_valid, 1);
        check("t3_p3_port",  iss_port,  2);
        tick();
        check("t3_still_blocked", iss_valid, 0);
        tick();
        cmp_valid = 1'b1; cmp_r1 = 4'd5;
        check("t3_pre_clr", iss_valid, 0);
        tick();
        check("t3_unblocked", iss_valid, 1);
        check("t3_port",      iss_port,  1);
        check("t3_cmd",       iss_cmd,   2);
        tick();

        // Overflow on port 4 with the pipe stalled.
        do_reset_async();
        iss_ready = 1'b0;
        set_req(3, 10, 3, 0, 0, 0, 100);
        tick();
        check("t4_full0", port_full, 0);
        set_req(3, 10, 3, 0, 0, 0, 101);
        tick();
        check("t4_full1",  port_full, 4'b1000);
        check("t4_nodrop", drop_err,  0);
        set_req(3, 10, 3, 0, 0, 0, 102);
        tick();
        check("t4_drop",      drop_err,  1);
        check("t4_drop_port", drop_port, 3);
        check("t4_full2",     port_full, 4'b1000);
        tick();
        check("t4_drop_gone", drop_err, 0);
        iss_ready = 1'b1;
        check("t4_head", iss_data, 100);
        tick();
        check("t4_second", iss_data, 101);
        tick();
        check("t4_empty", iss_valid, 0);

        // Grant of a writer and retire of the same register on one edge: set wins.
        do_reset_async();
        iss_ready = 1'b1;
        set_req(0, 5, 0, 0, 0, 7, 0);
        tick();
        cmp_valid = 1'b1; cmp_r1 = 4'd7;
        tick();
        check("t5_busy7",       busy_regs[7], 1);
        check("t5_model_busy7", mbusy[7],     1);

        // Reset with entries queued and busy bits set.
        iss_ready = 1'b0;
        set_req(1, 1, 0, 1, 2, 3, 0);
        tick();
        set_req(1, 9, 0, 0, 0, 4, 0);
        set_req(2, 1, 0, 0, 0, 8, 0);
        tick();
        check("t6_full_pre", port_full[1], 1);
        do_reset_async();
        cmp_valid = 1'b1; cmp_r1 = 4'd7;
        iss_ready = 1'b1;
        for (int p = 0; p < 4; p++) set_req(p, 12, 0, 0, 0, 0, 200 + p);
        tick();
        check("t6_busy_after", busy_regs, 0);
        check("t6_first_port", iss_port,  0);
        check("t6_first_data", iss_data,  200);

        // Randomized traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            iss_ready = ($urandom_range(0, 3) != 0);
            for (int p = 0; p < 4; p++)
                if ($urandom_range(0, 9) < 3)
                    set_req(p, $urandom_range(1, 15), $urandom_range(0, 3), $urandom_range(0, 15),
                            $urandom_range(0, 15), $urandom_range(0, 15), $urandom);
            if ($urandom_range(0, 9) < 4) begin
                cmp_valid = 1'b1;
                if (mbusy != '0 && $urandom_range(0, 3) != 0) begin
                    int k;
                    k = $urandom_range(0, 15);
                    while (!mbusy[k]) k = (k + 1) % 16;
                    cmp_r1 = 4'(k);
                end else begin
                    cmp_r1 = 4'($urandom_range(0, 15));
                end
            end
            if ($urandom_range(0, 599) == 0) do_reset_async();
            else tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
